// File: rtl/gb_wr_arb_rr_if.sv
// Write-port arbiter bus: per-channel requests and IDs on one side,
// SRAM write-controller handshake on the other.
interface gb_wr_arb_rr_if #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 6
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]      req;
  logic [NUM_CH*ID_W-1:0] id_in;
  logic                   wr_ack;
  logic                   wr_done;
  logic                   wr_req;
  logic [ID_W-1:0]        wr_id;
  logic [CH_W-1:0]        wr_ch;
  logic [NUM_CH-1:0]      gnt;
  logic                   busy;

  // Arbiter side
  modport master (
    input  req, id_in, wr_ack, wr_done,
    output wr_req, wr_id, wr_ch, gnt, busy
  );

  // Requesters / SRAM controller side
  modport slave (
    output req, id_in, wr_ack, wr_done,
    input  wr_req, wr_id, wr_ch, gnt, busy
  );
endinterface

// File: rtl/gb_wr_arb_rr.sv
// Global-buffer SRAM write-port arbiter: one fixed-priority channel with an
// anti-starvation cap, remaining channels served round-robin, and the
// req/ack/done handshake towards the SRAM write controller.
module gb_wr_arb_rr #(
  parameter int NUM_CH     = 4,
  parameter int ID_W       = 6,
  parameter int PRIO_CH    = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  gb_wr_arb_rr_if.master bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SC_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WRITE
  } state_t;

  state_t            state_q, state_n;
  logic              wr_req_q, wr_req_n;
  logic [ID_W-1:0]   wr_id_q, wr_id_n;
  logic [CH_W-1:0]   wr_ch_q, wr_ch_n;
  logic [NUM_CH-1:0] gnt_q, gnt_n;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_n;
  logic [SC_W-1:0]   starve_q, starve_n;

  logic              others_req;
  logic              prio_wins;
  logic              rr_found;
  logic [CH_W-1:0]   rr_win;
  logic [CH_W-1:0]   win;
  int unsigned       rr_idx;

  // Winner selection: priority channel unless capped, else first requester after rr_ptr
  always_comb begin
    others_req = 1'b0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (ch != PRIO_CH && bus.req[ch]) begin
        others_req = 1'b1;
      end
    end

    rr_found = 1'b0;
    rr_win   = '0;
    rr_idx   = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      rr_idx = (32'(rr_ptr_q) + i) % NUM_CH;
      if (!rr_found && rr_idx != PRIO_CH && bus.req[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = CH_W'(rr_idx);
      end
    end

    prio_wins = bus.req[PRIO_CH] &&
                (STARVE_MAX == 0 || starve_q < SC_W'(STARVE_MAX) || !others_req);
    win = prio_wins ? CH_W'(PRIO_CH) : rr_win;
  end

  // Next-state and registered-output logic for the handshake FSM
  always_comb begin
    state_n  = state_q;
    wr_req_n = wr_req_q;
    wr_id_n  = wr_id_q;
    wr_ch_n  = wr_ch_q;
    gnt_n    = '0;
    rr_ptr_n = rr_ptr_q;
    starve_n = starve_q;

    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          wr_id_n  = bus.id_in[win*ID_W +: ID_W];
          wr_ch_n  = win;
          wr_req_n = 1'b1;
          state_n  = S_REQ;
          if (!prio_wins) begin
            rr_ptr_n = win;
            starve_n = '0;
          end else if (others_req && starve_q != SC_W'(STARVE_MAX)) begin
            starve_n = starve_q + 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus.wr_ack) begin
          wr_req_n         = 1'b0;
          gnt_n[wr_ch_q]   = 1'b1;
          state_n          = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.wr_done) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_req_q <= 1'b0;
      wr_id_q  <= '0;
      wr_ch_q  <= '0;
      gnt_q    <= '0;
      rr_ptr_q <= CH_W'(NUM_CH - 1);
      starve_q <= '0;
    end else begin
      state_q  <= state_n;
      wr_req_q <= wr_req_n;
      wr_id_q  <= wr_id_n;
      wr_ch_q  <= wr_ch_n;
      gnt_q    <= gnt_n;
      rr_ptr_q <= rr_ptr_n;
      starve_q <= starve_n;
    end
  end

  assign bus.wr_req = wr_req_q;
  assign bus.wr_id  = wr_id_q;
  assign bus.wr_ch  = wr_ch_q;
  assign bus.gnt    = gnt_q;
  assign bus.busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_gb_wr_arb_rr.sv
// Self-checking bench for gb_wr_arb_rr: directed vector table, reset and
// handshake sequences, then random traffic checked against a queue-based model.
module tb_gb_wr_arb_rr;
  localparam int NUM_CH     = 4;
  localparam int ID_W       = 6;
  localparam int PRIO_CH    = 0;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  gb_wr_arb_rr_if #(.NUM_CH(NUM_CH), .ID_W(ID_W)) bus ();

  gb_wr_arb_rr #(
    .NUM_CH    (NUM_CH),
    .ID_W      (ID_W),
    .PRIO_CH   (PRIO_CH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Non-priority channels kept in current round-robin search order.
  int rr_q[$];
  int streak;

  function automatic void model_reset();
    rr_q.delete();
    for (int c = 0; c < NUM_CH; c++) if (c != PRIO_CH) rr_q.push_back(c);
    streak = 0;
  endfunction

  function automatic bit others_of(input logic [3:0] r);
    bit o;
    o = 1'b0;
    for (int c = 0; c < NUM_CH; c++) if (c != PRIO_CH && r[c]) o = 1'b1;
    return o;
  endfunction

  function automatic int model_pick(input logic [3:0] r);
    if (r[PRIO_CH] && (streak < STARVE_MAX || !others_of(r))) return PRIO_CH;
    foreach (rr_q[i]) if (r[rr_q[i]]) return rr_q[i];
    return -1;
  endfunction

  function automatic void model_commit(input int w, input logic [3:0] r);
    int x;
    if (w != PRIO_CH) begin
      // rotate so the winner goes last, its successors first
      while (rr_q[0] != w) begin x = rr_q.pop_front(); rr_q.push_back(x); end
      x = rr_q.pop_front();
      rr_q.push_back(x);
      streak = 0;
    end else if (others_of(r)) begin
      if (streak < STARVE_MAX) streak++;
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // One complete transfer; starts and ends at a negedge with the DUT idle.
  task automatic xfer(input logic [3:0] r, input logic [23:0] ids,
                      input int ackd, input int doned, input int exp_ch);
    logic [23:0] t;
    logic [5:0]  exp_id;
    logic [3:0]  exp_gnt;
    t       = ids;
    exp_id  = t[exp_ch*ID_W +: ID_W];
    exp_gnt = 4'(1 << exp_ch);
    bus.req   = r;
    bus.id_in = ids;
    @(negedge clk);
    chk("wr_req_rise", 32'(bus.wr_req), 32'd1);
    chk("wr_ch", 32'(bus.wr_ch), 32'(exp_ch));
    chk("wr_id", 32'(bus.wr_id), 32'(exp_id));
    chk("busy_req", 32'(bus.busy), 32'd1);
    chk("gnt_before_ack", 32'(bus.gnt), 32'd0);
    // requests and IDs are no longer sampled once the transfer has started
    bus.req   = 4'($urandom);
    bus.id_in = 24'($urandom);
    for (int i = 0; i < ackd; i++) begin
      @(negedge clk);
      chk("wr_req_hold", 32'(bus.wr_req), 32'd1);
      chk("wr_id_hold", 32'(bus.wr_id), 32'(exp_id));
      chk("gnt_wait_ack", 32'(bus.gnt), 32'd0);
      bus.id_in = 24'($urandom);
    end
    bus.wr_ack  = 1'b1;
    bus.wr_done = 1'($urandom);
    @(negedge clk);
    chk("gnt_pulse", 32'(bus.gnt), 32'(exp_gnt));
    chk("wr_req_drop", 32'(bus.wr_req), 32'd0);
    chk("busy_write", 32'(bus.busy), 32'd1);
    chk("wr_id_write", 32'(bus.wr_id), 32'(exp_id));
    bus.wr_ack  = 1'b0;
    bus.wr_done = 1'b0;
    for (int i = 0; i < doned; i++) begin
      @(negedge clk);
      chk("busy_wait_done", 32'(bus.busy), 32'd1);
      chk("gnt_one_cycle", 32'(bus.gnt), 32'd0);
    end
    bus.wr_done = 1'b1;
    @(negedge clk);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    chk("gnt_after_done", 32'(bus.gnt), 32'd0);
    chk("wr_req_after_done", 32'(bus.wr_req), 32'd0);
    bus.wr_done = 1'b0;
    bus.req     = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  req;
    logic [23:0] ids;
    int          ackd;
    int          doned;
    int          exp_ch;
  } vec_t;

  vec_t vecs[$];
  localparam logic [23:0] IDS    = {6'h3c, 6'h2b, 6'h1a, 6'h09};
  localparam logic [23:0] IDS_15 = {6'h3c, 6'h2b, 6'h15, 6'h09};

  function automatic void add(input logic [3:0] r, input logic [23:0] ids,
                              input int ackd, input int doned, input int ch);
    vec_t v;
    v.req = r; v.ids = ids; v.ackd = ackd; v.doned = doned; v.exp_ch = ch;
    vecs.push_back(v);
  endfunction

  int          w;
  logic [3:0]  r;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.req = '0; bus.id_in = '0; bus.wr_ack = 1'b0; bus.wr_done = 1'b0;

    // starvation cap from reset: ch0 x4, then each other channel in turn
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 4; j++) add(4'b1111, IDS, 0, 0, 0);
      add(4'b1111, IDS, 1, 0, k);
    end
    // round-robin among non-priority channels
    add(4'b1110, IDS, 0, 0, 1);
    add(4'b1110, IDS, 1, 2, 2);
    add(4'b1110, IDS, 2, 1, 3);
    add(4'b1110, IDS, 0, 0, 1);
    // priority alone never advances the starvation count
    for (int j = 0; j < 10; j++) add(4'b0001, IDS, j % 3, 0, 0);
    for (int j = 0; j < 4; j++) add(4'b1111, IDS, 0, 1, 0);
    add(4'b1111, IDS, 0, 0, 2);
    // single request with ack two cycles after wr_req rises
    add(4'b0010, IDS_15, 2, 1, 1);
    // ack held off for 20 cycles while id_in wanders
    add(4'b0100, IDS, 20, 2, 2);

    repeat (3) @(negedge clk);
    chk("rst_wr_req", 32'(bus.wr_req), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_wr_ch", 32'(bus.wr_ch), 32'd0);
    chk("rst_wr_id", 32'(bus.wr_id), 32'd0);
    rst = 1'b0;
    model_reset();

    // ack/done while idle do nothing
    bus.wr_ack = 1'b1; bus.wr_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack_busy", 32'(bus.busy), 32'd0);
      chk("idle_ack_gnt", 32'(bus.gnt), 32'd0);
    end
    bus.wr_ack = 1'b0; bus.wr_done = 1'b0;

    foreach (vecs[i]) begin
      xfer(vecs[i].req, vecs[i].ids, vecs[i].ackd, vecs[i].doned, vecs[i].exp_ch);
      model_commit(vecs[i].exp_ch, vecs[i].req);
    end

    // reset during REQ: no grant ever issued
    bus.req = 4'b0010; bus.id_in = IDS;
    @(negedge clk);
    chk("pre_rst_req", 32'(bus.wr_req), 32'd1);
    rst = 1'b1; bus.req = '0; bus.wr_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_req_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_req_wr_req", 32'(bus.wr_req), 32'd0);
      chk("rst_req_busy", 32'(bus.busy), 32'd0);
    end
    rst = 1'b0; bus.wr_ack = 1'b0;

    // reset during WRITE
    bus.req = 4'b1000;
    @(negedge clk);
    bus.wr_ack = 1'b1;
    @(negedge clk);
    bus.wr_ack = 1'b0;
    chk("pre_rst_write_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1; bus.req = '0;
    @(negedge clk);
    chk("rst_write_wr_req", 32'(bus.wr_req), 32'd0);
    chk("rst_write_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_write_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    model_reset();
    xfer(4'b0100, IDS, 1, 1, 2);
    model_commit(2, 4'b0100);

    // random traffic against the model
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req = '0;
        bus.wr_ack = 1'($urandom); bus.wr_done = 1'($urandom);
        @(negedge clk);
        chk("rand_idle_busy", 32'(bus.busy), 32'd0);
        chk("rand_idle_wr_req", 32'(bus.wr_req), 32'd0);
        bus.wr_ack = 1'b0; bus.wr_done = 1'b0;
      end
      r = 4'($urandom_range(1, 15));
      w = model_pick(r);
      xfer(r, 24'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), w);
      model_commit(w, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
